// File: rtl/per_port_demux.sv
// per_port_demux
// Steers whole packets from one merged AXI4-Stream input to one or more of
// N output ports. The destination is the one-hot field
// s_axis_tuser[C_DST_POS +: N] on a packet's first beat. Each port has its
// own fall-through FIFO, so a stalled port only blocks packets addressed
// to it. Packets with an empty destination are discarded and counted.
//
// Ports:
//   axi_aclk, axi_reset                  clock, synchronous active-high reset
//   s_axis_tdata/tstrb/tuser/tvalid/tlast/tready   merged input stream
//   m_axis_*_grp                         per-port output streams, port i in slice i
//   pkt_drop_cnt                         saturating count of dropped packets
//
// State | Meaning
// IDLE  | expecting the first beat of a packet
// FWD   | mid-packet, forwarding to the latched destination set
// DROP  | mid-packet, discarding the rest of an undeliverable packet

module per_port_demux #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_NUM_OUTPUT_IF    = 5,
    parameter int C_DST_POS            = 24,
    parameter int C_FIFO_DEPTH_BITS    = 2
) (
    input  logic                                              axi_aclk,
    input  logic                                              axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]                    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]                  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]                   s_axis_tuser,
    input  logic                                              s_axis_tvalid,
    output logic                                              s_axis_tready,
    input  logic                                              s_axis_tlast,
    output logic [C_M_NUM_OUTPUT_IF*C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata_grp,
    output logic [C_M_NUM_OUTPUT_IF*C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb_grp,
    output logic [C_M_NUM_OUTPUT_IF*C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser_grp,
    output logic [C_M_NUM_OUTPUT_IF-1:0]                      m_axis_tvalid_grp,
    input  logic [C_M_NUM_OUTPUT_IF-1:0]                      m_axis_tready_grp,
    output logic [C_M_NUM_OUTPUT_IF-1:0]                      m_axis_tlast_grp,
    output logic [31:0]                                       pkt_drop_cnt
);

    localparam int N     = C_M_NUM_OUTPUT_IF;
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int EW    = 1 + UW + SW + DW;
    localparam int PW    = C_FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << C_FIFO_DEPTH_BITS;
    localparam int CW    = C_FIFO_DEPTH_BITS + 1;
    localparam logic [CW-1:0] NF_LEVEL   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t         state, state_next;
    logic [N-1:0]   dst_reg, dst_next;
    logic [N-1:0]   dst_in;
    logic [N-1:0]   sel;
    logic [N-1:0]   push;
    logic [N-1:0]   nearly_full;
    logic [N-1:0]   empty;
    logic           space;
    logic           ready;
    logic           accept;
    logic           drop_inc;
    logic [EW-1:0]  entry;

    assign dst_in = s_axis_tuser[C_DST_POS +: N];
    assign entry  = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
    assign s_axis_tready = ready;

    // Readiness looks only at FIFO occupancy, never at downstream tready,
    // so there is no combinational path from m_axis_tready_grp.
    always_comb begin
        state_next = state;
        dst_next   = dst_reg;
        push       = '0;
        drop_inc   = 1'b0;
        ready      = 1'b0;
        sel        = (state == FWD) ? dst_reg : dst_in;
        space      = ((sel & nearly_full) == '0);

        case (state)
            IDLE:    ready = (dst_in == '0) ? 1'b1 : space;
            FWD:     ready = space;
            DROP:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
        if (axi_reset) begin
            ready = 1'b0;
        end

        accept = s_axis_tvalid && ready;

        if (accept) begin
            case (state)
                IDLE: begin
                    if (dst_in == '0) begin
                        drop_inc = 1'b1;
                        if (!s_axis_tlast) begin
                            state_next = DROP;
                        end
                    end else begin
                        push = dst_in;
                        if (!s_axis_tlast) begin
                            state_next = FWD;
                            dst_next   = dst_in;
                        end
                    end
                end
                FWD: begin
                    push = dst_reg;
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state        <= IDLE;
            dst_reg      <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            state   <= state_next;
            dst_reg <= dst_next;
            if (drop_inc && (pkt_drop_cnt != 32'hFFFF_FFFF)) begin
                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_port
        logic [EW-1:0] mem [DEPTH];
        logic [PW-1:0] rd_ptr, wr_ptr;
        logic [CW-1:0] count;
        logic [EW-1:0] head;
        logic          pop;

        assign head           = mem[rd_ptr];
        assign empty[i]       = (count == '0);
        assign nearly_full[i] = (count >= NF_LEVEL);
        assign pop            = !empty[i] && m_axis_tready_grp[i];

        // Storage is left unreset; contents are only observed when valid.
        always_ff @(posedge axi_aclk) begin
            if (push[i]) begin
                mem[wr_ptr] <= entry;
            end
        end

        always_ff @(posedge axi_aclk) begin
            if (axi_reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[i]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[i], pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        assign m_axis_tvalid_grp[i] = !empty[i];
        assign m_axis_tdata_grp[i*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH] = head[DW-1:0];
        assign m_axis_tstrb_grp[i*(C_M_AXIS_DATA_WIDTH/8) +: (C_M_AXIS_DATA_WIDTH/8)] = head[DW +: SW];
        assign m_axis_tuser_grp[i*C_M_AXIS_TUSER_WIDTH +: C_M_AXIS_TUSER_WIDTH] = head[DW+SW +: UW];
        assign m_axis_tlast_grp[i] = head[EW-1];

        // Admission stops at nearly-full, so a push into a full FIFO cannot occur.
        a_no_overflow: assert property (@(posedge axi_aclk) disable iff (axi_reset)
            !(push[i] && (count == FULL_LEVEL)));
    end

endmodule

// File: tb/tb_per_port_demux.sv
module tb_per_port_demux;

    localparam int N     = 5;
    localparam int DW    = 64;
    localparam int UW    = 32;
    localparam int SW    = DW / 8;
    localparam int DP    = 24;
    localparam int DB    = 2;
    localparam int DEPTH = 4;
    localparam int BW    = 1 + UW + SW + DW;

    typedef logic [BW-1:0] beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_tdata;
    logic [SW-1:0]     s_tstrb;
    logic [UW-1:0]     s_tuser;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [N*DW-1:0]   m_tdata;
    logic [N*SW-1:0]   m_tstrb;
    logic [N*UW-1:0]   m_tuser;
    logic [N-1:0]      m_tvalid;
    logic [N-1:0]      m_tready;
    logic [N-1:0]      m_tlast;
    logic [31:0]       drop_cnt;

    always #5 clk = ~clk;

    per_port_demux #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .C_M_NUM_OUTPUT_IF   (N),
        .C_DST_POS           (DP),
        .C_FIFO_DEPTH_BITS   (DB)
    ) dut (
        .axi_aclk         (clk),
        .axi_reset        (rst),
        .s_axis_tdata     (s_tdata),
        .s_axis_tstrb     (s_tstrb),
        .s_axis_tuser     (s_tuser),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .m_axis_tdata_grp (m_tdata),
        .m_axis_tstrb_grp (m_tstrb),
        .m_axis_tuser_grp (m_tuser),
        .m_axis_tvalid_grp(m_tvalid),
        .m_axis_tready_grp(m_tready),
        .m_axis_tlast_grp (m_tlast),
        .pkt_drop_cnt     (drop_cnt)
    );

    // Reference model: pending input beats, and per port the beats that
    // must still come out, in order.
    beat_t       drv_q[$];
    beat_t       exp_q[N][$];
    bit          in_pkt;
    bit          dropping;
    logic [N-1:0] pkt_dst;
    int unsigned m_drop;
    int          acc_cnt;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input logic [N-1:0] dst, input int len,
                           input int chg_beat, input logic [N-1:0] chg_dst);
        logic [UW-1:0] u;
        logic [N-1:0]  d;
        logic [SW-1:0] st;
        logic [DW-1:0] dt;
        for (int k = 0; k < len; k++) begin
            u  = $urandom;
            st = SW'($urandom);
            dt = {$urandom, $urandom};
            if (k == 0)             d = dst;
            else if (k == chg_beat) d = chg_dst;
            else                    d = N'($urandom);
            u[DP +: N] = d;
            drv_q.push_back({(k == len - 1), u, st, dt});
        end
    endtask

    task automatic cycle(input logic [N-1:0] rdy, input bit vld_en, input bit do_rst);
        beat_t        b;
        logic [N-1:0] dst_in;
        logic [N-1:0] sel;
        logic [N-1:0] pop;
        bit           exp_rdy;
        bit           acc;
        beat_t        obs;
        rst      = do_rst;
        m_tready = rdy;
        if (vld_en && drv_q.size() > 0) begin
            b = drv_q[0];
            s_tvalid = 1'b1;
        end else begin
            b = {1'b0, UW'($urandom), SW'($urandom), {$urandom, $urandom}};
            s_tvalid = 1'b0;
        end
        {s_tlast, s_tuser, s_tstrb, s_tdata} = b;

        @(negedge clk);
        dst_in  = s_tuser[DP +: N];
        sel     = (in_pkt && !dropping) ? pkt_dst : dst_in;
        exp_rdy = 1'b1;
        if (in_pkt && !dropping || (!in_pkt && dst_in != '0)) begin
            for (int i = 0; i < N; i++)
                if (sel[i] && exp_q[i].size() >= DEPTH - 1) exp_rdy = 1'b0;
        end
        if (do_rst) exp_rdy = 1'b0;

        check("s_axis_tready", s_tready, exp_rdy);
        check("pkt_drop_cnt", drop_cnt, m_drop);
        for (int i = 0; i < N; i++) begin
            check($sformatf("tvalid[%0d]", i), m_tvalid[i], exp_q[i].size() != 0);
            pop[i] = 1'b0;
            if (exp_q[i].size() != 0) begin
                obs = {m_tlast[i], m_tuser[i*UW +: UW], m_tstrb[i*SW +: SW], m_tdata[i*DW +: DW]};
                check($sformatf("beat[%0d]", i), obs, exp_q[i][0]);
                pop[i] = rdy[i];
            end
        end
        acc = s_tvalid && exp_rdy;

        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            in_pkt   = 1'b0;
            dropping = 1'b0;
            m_drop   = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (pop[i]) void'(exp_q[i].pop_front());
            if (acc) begin
                void'(drv_q.pop_front());
                acc_cnt++;
                if (!dropping) begin
                    for (int i = 0; i < N; i++)
                        if (sel[i]) exp_q[i].push_back(b);
                end
                if (!in_pkt && dst_in == '0 && m_drop != 32'hFFFF_FFFF) m_drop++;
                if (b[BW-1]) begin
                    in_pkt   = 1'b0;
                    dropping = 1'b0;
                end else if (!in_pkt) begin
                    in_pkt   = 1'b1;
                    dropping = (dst_in == '0);
                    pkt_dst  = dst_in;
                end
            end
        end
        #1;
    endtask

    task automatic run(input int n, input logic [N-1:0] rdy, input bit rand_vld);
        for (int k = 0; k < n; k++)
            cycle(rdy, rand_vld ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0);
    endtask

    task automatic drain();
        bit done;
        int k;
        done = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            cycle('1, 1'b1, 1'b0);
            k++;
            done = (drv_q.size() == 0);
            for (int i = 0; i < N; i++)
                if (exp_q[i].size() != 0) done = 1'b0;
        end
        check("drain_done", done, 1'b1);
    endtask

    initial begin
        int k;
        n_cmp = 0; n_err = 0; acc_cnt = 0;
        in_pkt = 1'b0; dropping = 1'b0; pkt_dst = '0; m_drop = 0;
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tdata = '0; s_tstrb = '0; s_tuser = '0; m_tready = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle('0, 1'b0, 1'b1);
        run(2, '1, 1'b0);

        // Unicast 3-beat packet to port 2.
        add_pkt(5'b00100, 3, -1, '0);
        drain();

        // Multicast to ports 0 and 4 with port 4 stalled, then released.
        add_pkt(5'b10001, 6, -1, '0);
        run(12, 5'b01111, 1'b0);
        drain();

        // Two dropped packets: 2 beats, then 1 beat.
        add_pkt('0, 2, -1, '0);
        add_pkt('0, 1, -1, '0);
        drain();
        check("drop_total", drop_cnt, 32'd2);

        // Head-of-line: port 1 stalled with a long packet, then a packet to port 3.
        add_pkt(5'b00010, 5, -1, '0);
        add_pkt(5'b01000, 3, -1, '0);
        run(15, 5'b11101, 1'b0);
        drain();

        // Later-beat destination bits are ignored.
        add_pkt(5'b00001, 4, 1, 5'b01000);
        drain();

        // Reset after beat 2 of a 4-beat packet.
        add_pkt(5'b00010, 4, -1, '0);
        acc_cnt = 0;
        k = 0;
        while (acc_cnt < 2 && k < 50) begin
            cycle('0, 1'b1, 1'b0);
            k++;
        end
        check("mid_reset_accepts", acc_cnt, 2);
        drv_q.delete();
        cycle('0, 1'b0, 1'b1);
        run(1, '1, 1'b0);
        add_pkt(5'b10000, 2, -1, '0);
        drain();

        // Randomized traffic with random valid and per-port ready.
        for (int c = 0; c < 500; c++) begin
            if (drv_q.size() < 3)
                add_pkt(N'($urandom_range(0, 31)), $urandom_range(1, 5), -1, '0);
            cycle(N'($urandom), bit'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
